audio_sample_fifo: RTL and testbench
====================================

Name: audio_sample_fifo

Overview:
- Single-clock, multi-channel circular sample FIFO between an audio source (already synchronised into the pixel domain) and the HDMI audio packet builder.
- Generalises the audio circular buffer in three ways:
  - any depth, not only powers of two;
  - an exact fill count that distinguishes full from empty;
  - a selectable overflow policy.
- Adds a valid handshake, flush, almost-full/almost-empty thresholds and sticky error flags.

Parameters:
- BUFFER_SIZE, 16: entries; any integer >= 2, need not be a power of two.
- BIT_WIDTH, 16: bits per channel sample.
- CHANNELS, 2: channels per entry; all channels move together.
- OVERFLOW_MODE, 0: 0 = drop newest, 1 = overwrite oldest, 2 = clear on overflow.
- ALMOST_FULL_LEVEL, BUFFER_SIZE-2: almost_full asserted when count >= this.
- ALMOST_EMPTY_LEVEL, 2: almost_empty asserted when count <= this.

Ports:
- clk_pixel  in  1  sole clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- audio_in_valid  in  1  push strobe; one sample per cycle when high.
- audio_in  in  [BIT_WIDTH-1:0] x [CHANNELS-1:0]  sample to push.
- packet_enable  in  1  pop strobe.
- flush  in  1  synchronous empty.
- flags_clear  in  1  clears the sticky flags.
- audio_out  out  [BIT_WIDTH-1:0] x [CHANNELS-1:0]  oldest entry, show-ahead.
- audio_out_valid  out  1  count != 0.
- remaining  out  $clog2(BUFFER_SIZE+1)  current fill count, 0..BUFFER_SIZE.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- overflow  out  1  sticky; a push arrived while full.
- underflow  out  1  sticky; a pop arrived while empty.

Behaviour:
- Reset (async assert, sync release): insert/remove pointers = 0, count = 0, overflow = underflow = 0.
  - Memory contents are not reset.
  - Outputs during reset: audio_out = 0, audio_out_valid = 0, remaining = 0, almost_empty = 1, almost_full = (ALMOST_FULL_LEVEL == 0).
- Pointers: range 0..BUFFER_SIZE-1; they wrap explicitly from BUFFER_SIZE-1 to 0 (no reliance on power-of-two overflow).
- Count: a register held separately from the pointers, never derived from the pointer difference.
- Show-ahead read:
  - audio_out is combinational from mem[remove_ptr] when count != 0, else all zeros.
  - A pop takes effect at the clock edge; the next entry appears on audio_out in the same cycle the updated count appears.
- Write latency: a push at edge N is visible on audio_out after edge N if the FIFO was empty before N. Zero-cycle fall-through to the pop in the same cycle is not allowed.
- remaining, almost_full and almost_empty are registered or derived combinationally from the registered count; they change only at edges.
- Per-cycle priority: reset > flush > push/pop.
- flush:
  - Pointers and count go to 0.
  - Any same-cycle push or pop is ignored.
  - No flags are set.
- Not full, not empty: push writes at insert_ptr and advances it; pop advances remove_ptr.
  - Both in one cycle: count unchanged.
- Empty:
  - Pop alone sets underflow; nothing moves.
  - Push + pop: push accepted, pop ignored, underflow set, count becomes 1.
- Full, push + pop in one cycle: both performed, count stays BUFFER_SIZE, no overflow.
- Full, push without pop: overflow set, then per OVERFLOW_MODE:
  - Mode 0: sample discarded, state unchanged.
  - Mode 1: sample written at insert_ptr; both pointers advance; count stays BUFFER_SIZE; the oldest sample is lost.
  - Mode 2: pointers and count reset to 0; the incoming sample is discarded.
- Sticky flags:
  - flags_clear zeroes overflow and underflow.
  - A same-cycle set event wins over the clear.
- Invalid parameters: BUFFER_SIZE < 2 or OVERFLOW_MODE > 2 → $fatal at elaboration.
- Storage is inferable as distributed RAM: one write port, one asynchronous read port.

Test Plan:
- Reset, then 5 pushes of {L,R} = {16'h0001+i, 16'h8001+i} with no pops → remaining = 5, audio_out = {0001,8001}, almost_empty = 0; then 5 pops return samples in order, remaining = 0, audio_out = 0, underflow = 0.
- BUFFER_SIZE = 6 (non-power-of-two), 20 interleaved push/pop cycles with a constant fill of 3 → pointer wrap exercised, output sequence strictly in order, remaining stays 3.
- Fill to 16 (remaining = 16, almost_full = 1), then push 16'hAAAA with no pop:
  - mode 0 → remaining = 16, head unchanged, overflow = 1;
  - mode 1 → head becomes the second sample, newest = AAAA;
  - mode 2 → remaining = 0, audio_out_valid = 0.
- Full buffer, push + pop in the same cycle → remaining stays 16, overflow stays 0, head advances by one.
- Empty buffer, pop alone → underflow = 1; then push + pop together → remaining = 1, audio_out = pushed value; flags_clear together with another empty pop → underflow remains 1.
- With 8 entries, assert flush together with a push; then drop reset_n asynchronously mid-burst of pushes → after flush, remaining = 0 and no flag is set; during reset, outputs hold their reset values; after release, the first push reads back correctly.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - multi-channel circular sample FIFO feeding the HDMI audio packet builder
//
// Purpose: single-clock show-ahead FIFO of multi-channel audio samples. Any depth >= 2,
// exact fill count, selectable overflow policy, flush and sticky error flags.
//
// Ports:
//   clk_pixel        sole clock, rising edge
//   reset_n          asynchronous active-low reset
//   audio_in_valid   push strobe, one entry per cycle
//   audio_in         entry to push, one BIT_WIDTH sample per channel
//   packet_enable    pop strobe
//   flush            synchronous empty, overrides push/pop
//   flags_clear      clears overflow/underflow (a same-cycle set wins)
//   audio_out        oldest entry (show-ahead), zero when empty
//   audio_out_valid  fill count is non-zero
//   remaining        fill count, 0..BUFFER_SIZE
//   almost_full      count >= ALMOST_FULL_LEVEL
//   almost_empty     count <= ALMOST_EMPTY_LEVEL
//   overflow         sticky, a push arrived while full without a pop
//   underflow        sticky, a pop arrived while empty
module audio_sample_fifo #(
    parameter int BUFFER_SIZE        = 16,
    parameter int BIT_WIDTH          = 16,
    parameter int CHANNELS           = 2,
    parameter int OVERFLOW_MODE      = 0,
    parameter int ALMOST_FULL_LEVEL  = BUFFER_SIZE - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    localparam int CNT_W             = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                               clk_pixel,
    input  logic                               reset_n,
    input  logic                               audio_in_valid,
    input  logic [CHANNELS-1:0][BIT_WIDTH-1:0] audio_in,
    input  logic                               packet_enable,
    input  logic                               flush,
    input  logic                               flags_clear,
    output logic [CHANNELS-1:0][BIT_WIDTH-1:0] audio_out,
    output logic                               audio_out_valid,
    output logic [CNT_W-1:0]                   remaining,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_SIZE);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(BUFFER_SIZE - 1);

    generate
        if (BUFFER_SIZE < 2 || OVERFLOW_MODE < 0 || OVERFLOW_MODE > 2) begin : g_bad_params
            $fatal(1, "audio_sample_fifo: BUFFER_SIZE must be >= 2 and OVERFLOW_MODE in 0..2");
        end
    endgenerate

    logic [CHANNELS-1:0][BIT_WIDTH-1:0] mem [BUFFER_SIZE];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             mem_we;
    logic             ovf_event;
    logic             udf_event;
    logic             is_empty;
    logic             is_full;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_COUNT);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        ovf_event = 1'b0;
        udf_event = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case ({audio_in_valid, packet_enable})
                2'b11: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    if (is_empty) begin
                        // No fall-through: the pop is refused, the push lands.
                        udf_event = 1'b1;
                        count_d   = CNT_W'(1);
                    end else begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                end
                2'b10: begin
                    if (!is_full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        count_d  = count_q + 1'b1;
                    end else begin
                        ovf_event = 1'b1;
                        if (OVERFLOW_MODE == 1) begin
                            // Full ring: the write slot is the oldest entry.
                            mem_we   = 1'b1;
                            wr_ptr_d = ptr_inc(wr_ptr_q);
                            rd_ptr_d = ptr_inc(rd_ptr_q);
                        end else if (OVERFLOW_MODE == 2) begin
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            count_d  = '0;
                        end
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        udf_event = 1'b1;
                    end else begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                        count_d  = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        overflow_d  = ovf_event | (overflow_q  & ~flags_clear);
        underflow_d = udf_event | (underflow_q & ~flags_clear);
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk_pixel) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= audio_in;
        end
    end

    assign audio_out       = is_empty ? '0 : mem[rd_ptr_q];
    assign audio_out_valid = !is_empty;
    assign remaining       = count_q;
    assign almost_full     = (int'(count_q) >= ALMOST_FULL_LEVEL);
    assign almost_empty    = (int'(count_q) <= ALMOST_EMPTY_LEVEL);
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - self-checking bench for audio_sample_fifo
module tb_audio_sample_fifo;

    logic              clk_pixel = 1'b0;
    logic              reset_n;
    logic              audio_in_valid;
    logic [1:0][15:0]  audio_in;
    logic              packet_enable;
    logic              flush;
    logic              flags_clear;

    // Instances 0..2: depth 16, overflow modes 0..2. Instance 3: depth 6, mode 0.
    logic [1:0][15:0]  out_w   [4];
    logic              valid_w [4];
    logic              af_w    [4];
    logic              ae_w    [4];
    logic              ov_w    [4];
    logic              un_w    [4];
    logic [4:0]        rem0, rem1, rem2;
    logic [2:0]        rem6;

    logic [31:0]       exp_q  [4][$];
    bit                exp_ov [4];
    bit                exp_un [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_pixel = ~clk_pixel;

    audio_sample_fifo #(.OVERFLOW_MODE(0)) u_m0 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .audio_in_valid(audio_in_valid),
        .audio_in(audio_in), .packet_enable(packet_enable), .flush(flush),
        .flags_clear(flags_clear), .audio_out(out_w[0]), .audio_out_valid(valid_w[0]),
        .remaining(rem0), .almost_full(af_w[0]), .almost_empty(ae_w[0]),
        .overflow(ov_w[0]), .underflow(un_w[0]));

    audio_sample_fifo #(.OVERFLOW_MODE(1)) u_m1 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .audio_in_valid(audio_in_valid),
        .audio_in(audio_in), .packet_enable(packet_enable), .flush(flush),
        .flags_clear(flags_clear), .audio_out(out_w[1]), .audio_out_valid(valid_w[1]),
        .remaining(rem1), .almost_full(af_w[1]), .almost_empty(ae_w[1]),
        .overflow(ov_w[1]), .underflow(un_w[1]));

    audio_sample_fifo #(.OVERFLOW_MODE(2)) u_m2 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .audio_in_valid(audio_in_valid),
        .audio_in(audio_in), .packet_enable(packet_enable), .flush(flush),
        .flags_clear(flags_clear), .audio_out(out_w[2]), .audio_out_valid(valid_w[2]),
        .remaining(rem2), .almost_full(af_w[2]), .almost_empty(ae_w[2]),
        .overflow(ov_w[2]), .underflow(un_w[2]));

    audio_sample_fifo #(.BUFFER_SIZE(6), .OVERFLOW_MODE(0)) u_s6 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .audio_in_valid(audio_in_valid),
        .audio_in(audio_in), .packet_enable(packet_enable), .flush(flush),
        .flags_clear(flags_clear), .audio_out(out_w[3]), .audio_out_valid(valid_w[3]),
        .remaining(rem6), .almost_full(af_w[3]), .almost_empty(ae_w[3]),
        .overflow(ov_w[3]), .underflow(un_w[3]));

    function automatic int dut_size(input int k);
        return (k == 3) ? 6 : 16;
    endfunction

    function automatic int dut_mode(input int k);
        return (k == 3) ? 0 : k;
    endfunction

    function automatic logic [31:0] dut_rem(input int k);
        case (k)
            0:       return 32'(rem0);
            1:       return 32'(rem1);
            2:       return 32'(rem2);
            default: return 32'(rem6);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Reference behaviour, applied once per rising edge with the inputs held for that edge.
    task automatic model_update();
        for (int k = 0; k < 4; k++) begin
            int cnt;
            bit so;
            bit su;
            cnt = exp_q[k].size();
            so  = 1'b0;
            su  = 1'b0;
            if (flush) begin
                exp_q[k].delete();
            end else if (audio_in_valid && packet_enable) begin
                if (cnt == 0) su = 1'b1;
                else void'(exp_q[k].pop_front());
                exp_q[k].push_back(audio_in);
            end else if (audio_in_valid) begin
                if (cnt < dut_size(k)) begin
                    exp_q[k].push_back(audio_in);
                end else begin
                    so = 1'b1;
                    if (dut_mode(k) == 1) begin
                        void'(exp_q[k].pop_front());
                        exp_q[k].push_back(audio_in);
                    end else if (dut_mode(k) == 2) begin
                        exp_q[k].delete();
                    end
                end
            end else if (packet_enable) begin
                if (cnt == 0) su = 1'b1;
                else void'(exp_q[k].pop_front());
            end
            exp_ov[k] = so | (exp_ov[k] & ~flags_clear);
            exp_un[k] = su | (exp_un[k] & ~flags_clear);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_ov[k] = 1'b0;
            exp_un[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            int          cnt;
            logic [31:0] head;
            cnt  = exp_q[k].size();
            head = (cnt != 0) ? exp_q[k][0] : 32'h0;
            check_eq($sformatf("out%0d", k),   32'(out_w[k]),   head);
            check_eq($sformatf("rem%0d", k),   dut_rem(k),      32'(cnt));
            check_eq($sformatf("valid%0d", k), 32'(valid_w[k]), 32'(cnt != 0));
            check_eq($sformatf("af%0d", k),    32'(af_w[k]),    32'(cnt >= dut_size(k) - 2));
            check_eq($sformatf("ae%0d", k),    32'(ae_w[k]),    32'(cnt <= 2));
            check_eq($sformatf("ov%0d", k),    32'(ov_w[k]),    32'(exp_ov[k]));
            check_eq($sformatf("un%0d", k),    32'(un_w[k]),    32'(exp_un[k]));
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic step(input bit push, input logic [31:0] d, input bit pop,
                        input bit fl = 1'b0, input bit clr = 1'b0);
        audio_in_valid = push;
        audio_in       = d;
        packet_enable  = pop;
        flush          = fl;
        flags_clear    = clr;
        @(posedge clk_pixel);
        model_update();
        @(negedge clk_pixel);
        audio_in_valid = 1'b0;
        packet_enable  = 1'b0;
        flush          = 1'b0;
        flags_clear    = 1'b0;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out"},   32'(out_w[0]),   32'h0);
        check_eq({tag, "_valid"}, 32'(valid_w[0]), 32'h0);
        check_eq({tag, "_rem"},   32'(rem0),       32'h0);
        check_eq({tag, "_ae"},    32'(ae_w[0]),    32'h1);
        check_eq({tag, "_af"},    32'(af_w[0]),    32'h0);
        check_eq({tag, "_rem6"},  32'(rem6),       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        audio_in_valid = 1'b0;
        audio_in       = '0;
        packet_enable  = 1'b0;
        flush          = 1'b0;
        flags_clear    = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk_pixel);
        reset_n = 1'b1;
        compare_all();

        // Five pushes then five pops, strictly in order.
        for (int i = 0; i < 5; i++) step(1'b1, {16'h0001 + 16'(i), 16'h8001 + 16'(i)}, 1'b0);
        check_eq("t1_rem", 32'(rem0), 32'd5);
        check_eq("t1_head", 32'(out_w[0]), 32'h0001_8001);
        check_eq("t1_ae", 32'(ae_w[0]), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("t1_rem_end", 32'(rem0), 32'd0);
        check_eq("t1_out_end", 32'(out_w[0]), 32'h0);
        check_eq("t1_un", 32'(un_w[0]), 32'h0);

        // Depth-6 ring at constant fill of 3 for 20 cycles: pointers wrap several times.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0100_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h0200_0000 + 32'(i), 1'b1);
        check_eq("t2_rem6", 32'(rem6), 32'd3);
        check_eq("t2_head6", 32'(out_w[3]), 32'h0200_0011);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // Fill to 16, then push AAAA with no pop under each overflow policy.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, {16'h1000 + 16'(i), 16'h2000 + 16'(i)}, 1'b0);
        check_eq("t3_rem_full", 32'(rem0), 32'd16);
        check_eq("t3_af", 32'(af_w[0]), 32'h1);
        step(1'b1, 32'hAAAA_AAAA, 1'b0);
        check_eq("t3_m0_rem", 32'(rem0), 32'd16);
        check_eq("t3_m0_head", 32'(out_w[0]), 32'h1000_2000);
        check_eq("t3_m0_ov", 32'(ov_w[0]), 32'h1);
        check_eq("t3_m1_head", 32'(out_w[1]), 32'h1001_2001);
        check_eq("t3_m1_rem", 32'(rem1), 32'd16);
        check_eq("t3_m2_rem", 32'(rem2), 32'd0);
        check_eq("t3_m2_valid", 32'(valid_w[2]), 32'h0);
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1);
        check_eq("t3_m1_newest", 32'(out_w[1]), 32'hAAAA_AAAA);
        step(1'b0, 32'h0, 1'b1);

        // Full buffer, simultaneous push and pop.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, {16'h3000 + 16'(i), 16'h4000 + 16'(i)}, 1'b0);
        step(1'b1, 32'h5555_5555, 1'b1);
        check_eq("t4_rem", 32'(rem0), 32'd16);
        check_eq("t4_ov", 32'(ov_w[0]), 32'h0);
        check_eq("t4_head", 32'(out_w[0]), 32'h3001_4001);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Underflow handling and sticky-flag clear priority.
        step(1'b0, 32'h0, 1'b1);
        check_eq("t5_un_set", 32'(un_w[0]), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("t5_un_clr", 32'(un_w[0]), 32'h0);
        step(1'b1, 32'h1234_5678, 1'b1);
        check_eq("t5_pp_rem", 32'(rem0), 32'd1);
        check_eq("t5_pp_out", 32'(out_w[0]), 32'h1234_5678);
        check_eq("t5_pp_un", 32'(un_w[0]), 32'h1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_eq("t5_set_wins", 32'(un_w[0]), 32'h1);

        // Flush with a same-cycle push, then asynchronous reset mid-burst.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0700_0000 + 32'(i), 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check_eq("t6_flush_rem", 32'(rem0), 32'd0);
        check_eq("t6_flush_ov", 32'(ov_w[0]), 32'h0);
        check_eq("t6_flush_un", 32'(un_w[0]), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0900_0000 + 32'(i), 1'b0);
        audio_in_valid = 1'b1;
        audio_in       = 32'h0900_0003;
        @(posedge clk_pixel);
        model_update();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk_pixel);
        compare_all();
        @(posedge clk_pixel);
        #1;
        check_reset_outputs("rst_held");
        @(negedge clk_pixel);
        audio_in_valid = 1'b0;
        reset_n        = 1'b1;
        compare_all();
        step(1'b1, 32'hCAFE_F00D, 1'b0);
        check_eq("t6_after_rst", 32'(out_w[0]), 32'hCAFE_F00D);
        check_eq("t6_after_rem", 32'(rem0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
